// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: fetches words over req/gnt + rvalid into a small FIFO for decode.
// Optional feature macro: PFQ_BYPASS_EN (same-cycle forwarding of a response into an empty queue).
module instr_prefetch_queue #(
  parameter int            DEPTH      = 4,
  parameter int            AW         = 10,
  parameter int            IW         = 10,
  parameter logic [AW-1:0] RESET_ADDR = {AW{1'b0}}
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic [AW-1:0] flush_addr,
  input  logic          halt,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [IW-1:0] mem_rdata,
  output logic          instr_valid,
  output logic [IW-1:0] instr,
  output logic [AW-1:0] instr_pc,
  input  logic          instr_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   CNT_ZERO  = {(PW+1){1'b0}};
  localparam logic [PW:0]   CNT_ONE   = {{PW{1'b0}}, 1'b1};
  localparam logic [PW:0]   CNT_DEPTH = (PW+1)'(DEPTH);
  localparam logic [PW-1:0] PTR_ZERO  = {PW{1'b0}};
  localparam logic [PW-1:0] PTR_ONE   = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  state_e          state_r;
  logic [AW-1:0]   fetch_addr_r;
  logic            drop_r;
  logic            mem_req_r;
  logic [IW-1:0]   instr_mem_r [DEPTH];
  logic [AW-1:0]   pc_mem_r    [DEPTH];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [PW:0]     count_r;
  logic [PW:0]     count_nxt_s;
  logic            rsp_s;
  logic            accept_s;
  logic            push_s;
  logic            pop_s;
  logic            byp_s;
  logic            byp_take_s;

  // A response only counts while waiting for it; a dropped or flushed one is discarded.
  assign rsp_s    = (state_r == ST_WAIT) && mem_rvalid;
  assign accept_s = rsp_s && !drop_r && !flush;
  assign pop_s    = !flush && (count_r != CNT_ZERO) && instr_ready;
  assign push_s   = accept_s && !byp_take_s;

`ifdef PFQ_BYPASS_EN
  assign byp_s      = accept_s && (count_r == CNT_ZERO);
  assign byp_take_s = byp_s && instr_ready;
`else
  assign byp_s      = 1'b0;
  assign byp_take_s = 1'b0;
`endif

  assign mem_req  = mem_req_r;
  assign mem_addr = fetch_addr_r;

  // Occupancy after this cycle's push/pop; flush empties the queue.
  always_comb begin
    count_nxt_s = count_r;
    if (flush) begin
      count_nxt_s = CNT_ZERO;
    end else if (push_s && !pop_s) begin
      count_nxt_s = count_r + CNT_ONE;
    end else if (!push_s && pop_s) begin
      count_nxt_s = count_r - CNT_ONE;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Fetch FSM: one outstanding request, issued only when its response has a free slot.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      fetch_addr_r <= RESET_ADDR;
      drop_r       <= 1'b0;
      mem_req_r    <= 1'b0;
    end else begin
      if (flush) begin
        fetch_addr_r <= flush_addr;
      end else if (accept_s) begin
        fetch_addr_r <= fetch_addr_r + ADDR_ONE;
      end
      case (state_r)
        ST_IDLE: begin
          if (!halt && !flush && !drop_r && (count_r < CNT_DEPTH)) begin
            state_r   <= ST_REQ;
            mem_req_r <= 1'b1;
          end else begin
            state_r   <= ST_IDLE;
            mem_req_r <= 1'b0;
          end
        end
        ST_REQ: begin
          if (mem_gnt) begin
            // A grant coinciding with flush is still outstanding and must be dropped.
            drop_r    <= flush;
            state_r   <= ST_WAIT;
            mem_req_r <= 1'b0;
          end else if (flush || halt) begin
            state_r   <= ST_IDLE;
            mem_req_r <= 1'b0;
          end else begin
            state_r   <= ST_REQ;
            mem_req_r <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            drop_r <= 1'b0;
            if (!flush && !halt && (count_nxt_s < CNT_DEPTH)) begin
              state_r   <= ST_REQ;
              mem_req_r <= 1'b1;
            end else begin
              state_r   <= ST_IDLE;
              mem_req_r <= 1'b0;
            end
          end else begin
            drop_r    <= drop_r | flush;
            state_r   <= ST_WAIT;
            mem_req_r <= 1'b0;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          drop_r    <= 1'b0;
          mem_req_r <= 1'b0;
        end
      endcase
    end
  end

  // FIFO storage and pointers; each entry holds a word and the address it came from.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_r[i] <= {IW{1'b0}};
        pc_mem_r[i]    <= {AW{1'b0}};
      end
    end else if (flush) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      if (push_s) begin
        instr_mem_r[wr_ptr_r] <= mem_rdata;
        pc_mem_r[wr_ptr_r]    <= fetch_addr_r;
        wr_ptr_r              <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_nxt_s;
    end
  end

  // Head presentation; outputs read zero whenever nothing is valid.
  always_comb begin
    instr_valid = 1'b0;
    instr       = {IW{1'b0}};
    instr_pc    = {AW{1'b0}};
    if (count_r != CNT_ZERO) begin
      instr_valid = 1'b1;
      instr       = instr_mem_r[rd_ptr_r];
      instr_pc    = pc_mem_r[rd_ptr_r];
    end else if (byp_s) begin
      instr_valid = 1'b1;
      instr       = mem_rdata;
      instr_pc    = fetch_addr_r;
    end else begin
      instr_valid = 1'b0;
      instr       = {IW{1'b0}};
      instr_pc    = {AW{1'b0}};
    end
  end

endmodule
